// File: rtl/ptw_pkg.sv
// rtl/ptw_pkg.sv - Sv32 walker shared widths, PTE field indices and FSM state type
package ptw_pkg;
    localparam int VPN_W      = 20;
    localparam int PPN_W      = 22;
    localparam int PTE_W      = 32;
    localparam int PAGE_SHIFT = 12;
    localparam int PA_W       = PPN_W + PAGE_SHIFT;
    localparam int IDX_W      = 10;

    localparam int PTE_BIT_V   = 0;
    localparam int PTE_BIT_R   = 1;
    localparam int PTE_BIT_W   = 2;
    localparam int PTE_BIT_X   = 3;
    localparam int PTE_PPN_LSB = 10;
    localparam int PTE_PPN_MSB = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } ptw_state_e;

    function automatic logic [IDX_W-1:0] vpn_index(input logic [VPN_W-1:0] vpn, input logic level);
        return level ? vpn[VPN_W-1:IDX_W] : vpn[IDX_W-1:0];
    endfunction
endpackage

// File: rtl/ptw_pte_check.sv
// rtl/ptw_pte_check.sv - combinational Sv32 PTE classifier (fault / leaf / misaligned superpage)
module ptw_pte_check
    import ptw_pkg::*;
(
    input  logic             level_i,
    input  logic [3:0]       flags_i,
    input  logic [IDX_W-1:0] ppn_lo_i,
    output logic             fault_o,
    output logic             leaf_o,
    output logic             misaligned_o
);
    // Write-without-read is a reserved encoding and faults like an invalid entry.
    assign fault_o      = ~flags_i[PTE_BIT_V] | (~flags_i[PTE_BIT_R] & flags_i[PTE_BIT_W]);
    assign leaf_o       = flags_i[PTE_BIT_R] | flags_i[PTE_BIT_X];
    assign misaligned_o = leaf_o & level_i & (ppn_lo_i != '0);
endmodule

// File: rtl/ptw_walk_ctrl.sv
// rtl/ptw_walk_ctrl.sv - Sv32 two-level page-table-walk controller, one walk at a time
// Optional one-entry level-1 pointer cache enabled by defining PTW_CACHE_EN.
module ptw_walk_ctrl
    import ptw_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    output logic             io_req_ready,
    input  logic             io_req_valid,
    input  logic             io_req_bits_valid,
    input  logic [VPN_W-1:0] io_req_bits_bits_addr,
    input  logic             io_req_bits_bits_need_gpa,
    input  logic             io_req_chosen,
    input  logic [PPN_W-1:0] io_satp_ppn,
    input  logic             io_sfence,
    output logic             io_mem_req_valid,
    input  logic             io_mem_req_ready,
    output logic [PA_W-1:0]  io_mem_req_addr,
    input  logic             io_mem_resp_valid,
    input  logic [PTE_W-1:0] io_mem_resp_data,
    input  logic             io_mem_resp_err,
    output logic             io_resp_0_valid,
    output logic             io_resp_1_valid,
    output logic [PTE_W-1:0] io_resp_pte,
    output logic             io_resp_level,
    output logic             io_resp_pf,
    output logic             io_resp_ae,
    output logic             io_resp_need_gpa
);
    ptw_state_e       state_q, state_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [PPN_W-1:0] ppn_q, ppn_d;
    logic             level_q, level_d;
    logic             need_gpa_q, need_gpa_d;
    logic             chosen_q, chosen_d;
    logic [PTE_W-1:0] res_pte_q, res_pte_d;
    logic             res_level_q, res_level_d;
    logic             pf_q, pf_d;
    logic             ae_q, ae_d;
    logic             descend;
    logic             cache_hit;
    logic [PPN_W-1:0] cache_ppn;
    logic             pte_fault, pte_leaf, pte_misaligned;

    ptw_pte_check u_pte_check (
        .level_i      (level_q),
        .flags_i      (io_mem_resp_data[3:0]),
        .ppn_lo_i     (io_mem_resp_data[PTE_PPN_LSB +: IDX_W]),
        .fault_o      (pte_fault),
        .leaf_o       (pte_leaf),
        .misaligned_o (pte_misaligned)
    );

    assign io_mem_req_addr  = {ppn_q, {PAGE_SHIFT{1'b0}}}
                            + {{(PA_W-IDX_W-2){1'b0}}, vpn_index(vpn_q, level_q), 2'b00};
    assign io_resp_pte      = res_pte_q;
    assign io_resp_level    = res_level_q;
    assign io_resp_pf       = pf_q;
    assign io_resp_ae       = ae_q;
    assign io_resp_need_gpa = need_gpa_q;

`ifdef PTW_CACHE_EN
    logic                   c_valid_q;
    logic [PPN_W+IDX_W-1:0] c_tag_q;
    logic [PPN_W-1:0]       c_ppn_q;
    logic                   sfence_seen_q, sfence_seen_d;

    // A flush in the accept cycle must not let the stale entry steer the new walk.
    assign cache_hit = c_valid_q & ~io_sfence
                     & (c_tag_q == {io_satp_ppn, io_req_bits_bits_addr[VPN_W-1:IDX_W]});
    assign cache_ppn = c_ppn_q;
    assign sfence_seen_d = (state_q == ST_IDLE) ? io_sfence : (sfence_seen_q | io_sfence);

    always_ff @(posedge clock) begin
        if (reset) begin
            c_valid_q     <= 1'b0;
            c_tag_q       <= '0;
            c_ppn_q       <= '0;
            sfence_seen_q <= 1'b0;
        end else begin
            sfence_seen_q <= sfence_seen_d;
            if (io_sfence) begin
                c_valid_q <= 1'b0;
            end else if (descend && !sfence_seen_q) begin
                // ppn_q still holds the root table PPN while at level 1.
                c_valid_q <= 1'b1;
                c_tag_q   <= {ppn_q, vpn_q[VPN_W-1:IDX_W]};
                c_ppn_q   <= io_mem_resp_data[PTE_PPN_MSB:PTE_PPN_LSB];
            end
        end
    end
`else
    logic unused_sfence;
    assign unused_sfence = io_sfence;
    assign cache_hit     = 1'b0;
    assign cache_ppn     = '0;
`endif

    always_comb begin
        state_d          = state_q;
        vpn_d            = vpn_q;
        ppn_d            = ppn_q;
        level_d          = level_q;
        need_gpa_d       = need_gpa_q;
        chosen_d         = chosen_q;
        res_pte_d        = res_pte_q;
        res_level_d      = res_level_q;
        pf_d             = pf_q;
        ae_d             = ae_q;
        descend          = 1'b0;
        io_req_ready     = 1'b0;
        io_mem_req_valid = 1'b0;
        io_resp_0_valid  = 1'b0;
        io_resp_1_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                io_req_ready = 1'b1;
                if (io_req_valid && io_req_bits_valid) begin
                    vpn_d      = io_req_bits_bits_addr;
                    need_gpa_d = io_req_bits_bits_need_gpa;
                    chosen_d   = io_req_chosen;
                    ppn_d      = io_satp_ppn;
                    level_d    = 1'b1;
                    if (cache_hit) begin
                        ppn_d   = cache_ppn;
                        level_d = 1'b0;
                    end
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                io_mem_req_valid = 1'b1;
                if (io_mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (io_mem_resp_valid) begin
                    state_d     = ST_RESP;
                    res_level_d = level_q;
                    res_pte_d   = '0;
                    pf_d        = 1'b0;
                    ae_d        = 1'b0;
                    if (io_mem_resp_err) begin
                        ae_d = 1'b1;
                    end else if (pte_fault) begin
                        pf_d = 1'b1;
                    end else if (pte_leaf) begin
                        if (pte_misaligned) pf_d = 1'b1;
                        else res_pte_d = io_mem_resp_data;
                    end else if (!level_q) begin
                        pf_d = 1'b1;
                    end else begin
                        descend = 1'b1;
                        ppn_d   = io_mem_resp_data[PTE_PPN_MSB:PTE_PPN_LSB];
                        level_d = 1'b0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_RESP: begin
                io_resp_0_valid = ~chosen_q;
                io_resp_1_valid = chosen_q;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vpn_q       <= '0;
            ppn_q       <= '0;
            level_q     <= 1'b1;
            need_gpa_q  <= 1'b0;
            chosen_q    <= 1'b0;
            res_pte_q   <= '0;
            res_level_q <= 1'b0;
            pf_q        <= 1'b0;
            ae_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            vpn_q       <= vpn_d;
            ppn_q       <= ppn_d;
            level_q     <= level_d;
            need_gpa_q  <= need_gpa_d;
            chosen_q    <= chosen_d;
            res_pte_q   <= res_pte_d;
            res_level_q <= res_level_d;
            pf_q        <= pf_d;
            ae_q        <= ae_d;
        end
    end
endmodule

// File: tb/tb_ptw_walk_ctrl.sv
// tb/tb_ptw_walk_ctrl.sv - self-checking bench for ptw_walk_ctrl against a walk-level reference model
// Cache-specific steps are compiled in when PTW_CACHE_EN is defined.
module tb_ptw_walk_ctrl;
`ifdef PTW_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        io_req_ready, io_req_valid, io_req_bits_valid, io_req_bits_bits_need_gpa, io_req_chosen;
    logic [19:0] io_req_bits_bits_addr;
    logic [21:0] io_satp_ppn;
    logic        io_sfence;
    logic        io_mem_req_valid, io_mem_req_ready;
    logic [33:0] io_mem_req_addr;
    logic        io_mem_resp_valid, io_mem_resp_err;
    logic [31:0] io_mem_resp_data;
    logic        io_resp_0_valid, io_resp_1_valid, io_resp_level, io_resp_pf, io_resp_ae, io_resp_need_gpa;
    logic [31:0] io_resp_pte;

    ptw_walk_ctrl dut (
        .clock(clock), .reset(reset),
        .io_req_ready(io_req_ready), .io_req_valid(io_req_valid),
        .io_req_bits_valid(io_req_bits_valid), .io_req_bits_bits_addr(io_req_bits_bits_addr),
        .io_req_bits_bits_need_gpa(io_req_bits_bits_need_gpa), .io_req_chosen(io_req_chosen),
        .io_satp_ppn(io_satp_ppn), .io_sfence(io_sfence),
        .io_mem_req_valid(io_mem_req_valid), .io_mem_req_ready(io_mem_req_ready),
        .io_mem_req_addr(io_mem_req_addr), .io_mem_resp_valid(io_mem_resp_valid),
        .io_mem_resp_data(io_mem_resp_data), .io_mem_resp_err(io_mem_resp_err),
        .io_resp_0_valid(io_resp_0_valid), .io_resp_1_valid(io_resp_1_valid),
        .io_resp_pte(io_resp_pte), .io_resp_level(io_resp_level), .io_resp_pf(io_resp_pf),
        .io_resp_ae(io_resp_ae), .io_resp_need_gpa(io_resp_need_gpa)
    );

    typedef struct { logic idx; logic [31:0] pte; logic level, pf, ae, ngpa; int cyc; } resp_t;
    typedef struct { logic [31:0] pte; logic level, pf, ae; int n; logic [33:0] a0, a1; } exp_t;

    int total = 0, bad = 0, cyc = 0;
    logic [31:0] mem    [logic [33:0]];
    bit          err_at [logic [33:0]];
    logic [33:0] addr_log[$];
    resp_t       resp_q[$];
    resp_t       last_r;
    int          last_base, last_n;
    int          stall_cnt = 0, stall_seen = 0, resp_delay = 0;
    bit          prev_stalled = 0;
    logic [33:0] held_addr;
    bit          mc_valid = 0;
    logic [21:0] mc_root, mc_ppn;
    logic [9:0]  mc_vpn1;

    initial forever #5 clock = ~clock;
    initial forever begin @(posedge clock); cyc++; end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory port: logs each accepted request, answers resp_delay cycles after it.
    initial begin
        bit pend_v = 0;
        int pend_c = 0;
        logic [33:0] pend_a = '0;
        forever begin
            @(negedge clock);
            if (io_mem_req_valid && io_mem_req_ready) begin
                addr_log.push_back(io_mem_req_addr);
                pend_v = 1; pend_a = io_mem_req_addr; pend_c = resp_delay;
            end
            @(posedge clock); #1;
            io_mem_resp_valid = 0; io_mem_resp_data = '0; io_mem_resp_err = 0;
            if (pend_v) begin
                if (pend_c == 0) begin
                    io_mem_resp_valid = 1;
                    io_mem_resp_data  = mem.exists(pend_a) ? mem[pend_a] : 32'h0;
                    io_mem_resp_err   = err_at.exists(pend_a) ? err_at[pend_a] : 1'b0;
                    pend_v = 0;
                end else pend_c--;
            end
            if (stall_cnt > 0 && io_mem_req_valid) begin
                io_mem_req_ready = 0; stall_cnt--;
            end else io_mem_req_ready = 1;
        end
    end

    initial forever begin
        @(negedge clock);
        if (io_resp_0_valid || io_resp_1_valid) begin
            resp_q.push_back('{io_resp_1_valid, io_resp_pte, io_resp_level, io_resp_pf,
                               io_resp_ae, io_resp_need_gpa, cyc});
            check("resp_onehot", {63'b0, io_resp_0_valid && io_resp_1_valid}, 64'd0);
        end
        if (io_mem_req_valid && !io_mem_req_ready) begin
            check("stall_req_ready", {63'b0, io_req_ready}, 64'd0);
            if (prev_stalled) check("stall_addr_held", {30'b0, io_mem_req_addr}, {30'b0, held_addr});
            held_addr = io_mem_req_addr; stall_seen++; prev_stalled = 1;
        end else prev_stalled = 0;
    end

    // Reference walk: reads the same table the memory port serves, one level per access.
    function automatic exp_t model(input logic [21:0] root, input logic [19:0] vpn);
        exp_t e; logic [21:0] base; logic lvl; logic [31:0] p; logic [33:0] a; logic [9:0] idx; bit done;
        e.pte = 0; e.level = 0; e.pf = 0; e.ae = 0; e.n = 0; e.a0 = 0; e.a1 = 0;
        base = root; lvl = 1; done = 0;
        if (CACHE_EN && mc_valid && mc_root == root && mc_vpn1 == vpn[19:10]) begin
            base = mc_ppn; lvl = 0;
        end
        while (!done) begin
            idx = lvl ? vpn[19:10] : vpn[9:0];
            a = 34'(base) * 34'd4096 + 34'(idx) * 34'd4;
            if (e.n == 0) e.a0 = a; else e.a1 = a;
            e.n++;
            p = mem.exists(a) ? mem[a] : 32'h0;
            e.level = lvl; done = 1;
            if (err_at.exists(a) && err_at[a]) e.ae = 1;
            else if (!p[0] || (!p[1] && p[2])) e.pf = 1;
            else if (p[1] || p[3]) begin
                if (lvl && p[19:10] != 0) e.pf = 1; else e.pte = p;
            end else if (!lvl) e.pf = 1;
            else begin
                if (CACHE_EN) begin mc_valid = 1; mc_root = root; mc_vpn1 = vpn[19:10]; mc_ppn = p[31:10]; end
                base = p[31:10]; lvl = 0; done = 0;
            end
        end
        return e;
    endfunction

    task automatic sfence_pulse();
        @(negedge clock); io_sfence = 1;
        @(negedge clock); io_sfence = 0;
        mc_valid = 0;
    endtask

    task automatic do_walk(input logic [21:0] satp, input logic [19:0] vpn, input logic ch,
                           input logic ng, input logic bv, input int lat, input string tag);
        exp_t e; int w, acc; resp_t r;
        resp_q.delete();
        @(negedge clock);
        w = 0;
        while (!io_req_ready && w < 50) begin @(negedge clock); w++; end
        check({tag, "_req_ready"}, {63'b0, io_req_ready}, 64'd1);
        if (bv) e = model(satp, vpn);
        last_base = addr_log.size();
        io_req_valid = 1; io_req_bits_valid = bv; io_req_bits_bits_addr = vpn;
        io_req_bits_bits_need_gpa = ng; io_req_chosen = ch; io_satp_ppn = satp;
        acc = cyc;
        @(posedge clock); #1;
        io_req_valid = 0; io_req_bits_valid = 0; io_satp_ppn = $urandom;
        if (bv) begin
            w = 0;
            while (resp_q.size() == 0 && w < 60) begin @(negedge clock); w++; end
            check({tag, "_resp_seen"}, {63'b0, resp_q.size() != 0}, 64'd1);
            last_n = addr_log.size() - last_base;
            check({tag, "_n_access"}, 64'(last_n), 64'(e.n));
            if (last_n >= 1) check({tag, "_addr0"}, {30'b0, addr_log[last_base]}, {30'b0, e.a0});
            if (last_n >= 2) check({tag, "_addr1"}, {30'b0, addr_log[last_base+1]}, {30'b0, e.a1});
            if (resp_q.size() != 0) begin
                r = resp_q.pop_front(); last_r = r;
                check({tag, "_idx"},   {63'b0, r.idx},   {63'b0, ch});
                check({tag, "_pte"},   {32'b0, r.pte},   {32'b0, e.pte});
                check({tag, "_level"}, {63'b0, r.level}, {63'b0, e.level});
                check({tag, "_pf"},    {63'b0, r.pf},    {63'b0, e.pf});
                check({tag, "_ae"},    {63'b0, r.ae},    {63'b0, e.ae});
                check({tag, "_ngpa"},  {63'b0, r.ngpa},  {63'b0, ng});
                if (lat >= 0) check({tag, "_latency"}, 64'(r.cyc - acc), 64'(lat));
            end
        end else begin
            repeat (10) @(negedge clock);
            check({tag, "_no_resp"}, 64'(resp_q.size()), 64'd0);
            check({tag, "_no_mem"}, 64'(addr_log.size() - last_base), 64'd0);
            check({tag, "_idle"}, {63'b0, io_req_ready}, 64'd1);
        end
    endtask

    function automatic logic [31:0] gen_pte(input int kind);
        logic [21:0] p;
        p = 22'($urandom_range(3, 40));
        case (kind)
            0: return 32'h0;
            1: return {p, 10'h001};
            2: return {p, 10'h00F};
            3: return {p[11:0], 10'h000, 10'h00F};
            4: return {p, 10'h00B};
            5: return {p, 10'h005};
            default: return {p, 10'h009};
        endcase
    endfunction

    initial begin
        int w, base;
        logic [21:0] satp; logic [19:0] vpn; logic [33:0] a1; logic [31:0] p1;
        reset = 1; io_req_valid = 0; io_req_bits_valid = 0; io_req_bits_bits_addr = 0;
        io_req_bits_bits_need_gpa = 0; io_req_chosen = 0; io_satp_ppn = 0; io_sfence = 0;
        io_mem_req_ready = 1; io_mem_resp_valid = 0; io_mem_resp_data = 0; io_mem_resp_err = 0;
        repeat (3) @(negedge clock);
        reset = 0;
        @(negedge clock);
        check("rst_req_ready", {63'b0, io_req_ready}, 64'd1);
        check("rst_mem_valid", {63'b0, io_mem_req_valid}, 64'd0);
        check("rst_resp_valid", {62'b0, io_resp_0_valid, io_resp_1_valid}, 64'd0);
        check("rst_fields", {28'b0, io_resp_pte, io_resp_level, io_resp_pf, io_resp_ae, io_resp_need_gpa}, 64'd0);

        mem[34'h1004] = 32'h00000801; mem[34'h2004] = 32'h0000200F;
        do_walk(22'h1, 20'h00401, 0, 1, 1, 5, "two_level");
        check("two_level_a0_const", {30'b0, addr_log[last_base]}, 64'h1004);
        check("two_level_a1_const", {30'b0, addr_log[last_base+1]}, 64'h2004);
        check("two_level_pte_const", {32'b0, last_r.pte}, 64'h200F);

        sfence_pulse();
        mem[34'h1004] = 32'h0040000F;
        do_walk(22'h1, 20'h00401, 1, 0, 1, 3, "superpage");
        check("superpage_level_const", {63'b0, last_r.level}, 64'd1);

        mem[34'h1004] = 32'h0000040F;
        do_walk(22'h1, 20'h00401, 0, 0, 1, 3, "misaligned");
        check("misaligned_pf_const", {63'b0, last_r.pf}, 64'd1);
        mem[34'h1004] = 32'h0;
        do_walk(22'h1, 20'h00401, 1, 0, 1, 3, "invalid");
        mem[34'h1004] = 32'h00000801; err_at[34'h1004] = 1;
        do_walk(22'h1, 20'h00401, 0, 0, 1, 3, "bus_err");
        check("bus_err_ae_const", {63'b0, last_r.ae}, 64'd1);
        err_at[34'h1004] = 0;

        sfence_pulse();
        stall_cnt = 3; stall_seen = 0;
        do_walk(22'h1, 20'h00401, 0, 0, 1, 8, "stall");
        check("stall_cycles", 64'(stall_seen), 64'd3);

        do_walk(22'h1, 20'h00401, 1, 1, 0, -1, "noop");

        sfence_pulse();
        resp_delay = 4; resp_q.delete(); base = addr_log.size();
        @(negedge clock);
        io_req_valid = 1; io_req_bits_valid = 1; io_req_bits_bits_addr = 20'h00401; io_satp_ppn = 22'h1;
        @(posedge clock); #1;
        io_req_valid = 0; io_req_bits_valid = 0;
        w = 0;
        while (addr_log.size() == base && w < 20) begin @(negedge clock); w++; end
        check("rst_wait_handshake", {63'b0, addr_log.size() > base}, 64'd1);
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0; mc_valid = 0;
        check("rst_wait_mem_valid", {63'b0, io_mem_req_valid}, 64'd0);
        check("rst_wait_idle", {63'b0, io_req_ready}, 64'd1);
        repeat (8) @(negedge clock);
        check("rst_wait_late_ignored", 64'(resp_q.size()), 64'd0);
        check("rst_wait_still_idle", {63'b0, io_req_ready}, 64'd1);
        resp_delay = 0;

`ifdef PTW_CACHE_EN
        sfence_pulse();
        mem[34'h1004] = 32'h00000801; mem[34'h2004] = 32'h0000200F; mem[34'h2008] = 32'h0000300F;
        do_walk(22'h1, 20'h00401, 0, 0, 1, 5, "cache_fill");
        check("cache_fill_n_const", 64'(last_n), 64'd2);
        do_walk(22'h1, 20'h00402, 1, 0, 1, 3, "cache_hit");
        check("cache_hit_n_const", 64'(last_n), 64'd1);
        check("cache_hit_addr_const", {30'b0, addr_log[last_base]}, 64'h2008);
        sfence_pulse();
        do_walk(22'h1, 20'h00402, 0, 0, 1, 5, "cache_flushed");
        check("cache_flushed_n_const", 64'(last_n), 64'd2);
`endif

        for (int i = 0; i < 40; i++) begin
            satp = 22'($urandom_range(1, 2));
            vpn  = {10'($urandom_range(0, 3)), 10'($urandom)};
            a1   = 34'(satp) * 34'd4096 + 34'(vpn[19:10]) * 34'd4;
            p1   = gen_pte($urandom_range(0, 6));
            mem[a1] = p1; err_at[a1] = ($urandom_range(0, 7) == 0);
            if (p1[3:0] == 4'h1) begin
                mem[34'(p1[31:10]) * 34'd4096 + 34'(vpn[9:0]) * 34'd4] = gen_pte($urandom_range(0, 6));
                err_at[34'(p1[31:10]) * 34'd4096 + 34'(vpn[9:0]) * 34'd4] = ($urandom_range(0, 7) == 0);
            end
            stall_cnt = $urandom_range(0, 2);
            do_walk(satp, vpn, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0), -1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
